muldiv_unit: RTL and testbench

//   Iterative 64-bit multiply/divide unit answering the EX stage's muldiv request interface.
//   EX drives operands, per-operand sign flags, op select and req_valid; this block returns

---
 rtl/muldiv_unit_if.sv | 46 ++++
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Request/response bundle between the EX stage and the iterative
//   multiply/divide unit.
//   master modport : EX side (drives request, observes status/result)
//   slave  modport : muldiv_unit side
//   Signals:
//     req_valid_i   request level, held by EX until resp_valid_o
//     mul_en_i      1 = multiply, 0 = divide/remainder
//     rs1_data_i    multiplicand / dividend
//     rs2_data_i    multiplier / divisor
//     rs1_sign_i    rs1 is signed
//     rs2_sign_i    rs2 is signed
//     flush_i       abort the operation in flight
//     busy_o        unit not idle (EX stall source)
//     resp_valid_o  one-cycle result strobe
//     data_1_o      product low half / quotient
//     data_2_o      product high half / remainder
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
   parameter int XLEN = 64
);
   logic            req_valid_i;
   logic            mul_en_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic            rs1_sign_i;
   logic            rs2_sign_i;
   logic            flush_i;
   logic            busy_o;
   logic            resp_valid_o;
   logic [XLEN-1:0] data_1_o;
   logic [XLEN-1:0] data_2_o;

   modport master (
      output req_valid_i, mul_en_i, rs1_data_i, rs2_data_i,
             rs1_sign_i, rs2_sign_i, flush_i,
      input  busy_o, resp_valid_o, data_1_o, data_2_o
   );

   modport slave (
      input  req_valid_i, mul_en_i, rs1_data_i, rs2_data_i,
             rs1_sign_i, rs2_sign_i, flush_i,
      output busy_o, resp_valid_o, data_1_o, data_2_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative XLEN-bit multiply/divide unit for the EX stage.
//   Multiply: radix-2 shift-add, one multiplier bit per cycle, 2*XLEN product.
//   Divide:   restoring, one quotient bit per cycle.
//   FSM IDLE -> CALC -> FIX -> DONE -> IDLE; resp_valid_o is high in DONE.
//   Operands are converted to magnitudes on accept; the result sign is
//   applied in FIX.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   muldiv_unit_if.slave (request, operands, flush, busy, results)
//
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, multiply leaves CALC as soon as the
//                        remaining multiplier bits are zero (|b|==0 skips
//                        CALC), and divide-by-zero / signed overflow go
//                        straight from IDLE to FIX. Results are identical.
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;
`else
   localparam bit EARLY_OUT = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic [XLEN-1:0] cneg_x(input logic [XLEN-1:0] v,
                                              input logic en);
      return en ? -v : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cneg_w(input logic [2*XLEN-1:0] v,
                                                input logic en);
      return en ? -v : v;
   endfunction

   logic [1:0]        state_q;
   logic              op_mul_q;
   logic              neg_1_q;     // negate product / quotient in FIX
   logic              neg_2_q;     // negate remainder in FIX
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] acc_q;       // product accumulator
   logic [2*XLEN-1:0] mcand_q;     // multiplicand, shifted left each step
   logic [XLEN-1:0]   opb_q;       // multiplier (shifted right) / divisor
   logic [XLEN-1:0]   quo_q;       // dividend shifting out, quotient in
   logic [XLEN-1:0]   rem_q;       // partial remainder
   logic [XLEN-1:0]   data_1_q;
   logic [XLEN-1:0]   data_2_q;

   // accept-cycle operand decode
   logic signed [XLEN-1:0] rs1_s;
   logic signed [XLEN-1:0] rs2_s;
   logic                   sa;
   logic                   sb;
   logic [XLEN-1:0]        mag_a;
   logic [XLEN-1:0]        mag_b;
   logic                   div_zero;
   logic                   div_ovf;

   assign rs1_s    = signed'(bus.rs1_data_i);
   assign rs2_s    = signed'(bus.rs2_data_i);
   assign sa       = bus.rs1_sign_i & (rs1_s < 0);
   assign sb       = bus.rs2_sign_i & (rs2_s < 0);
   assign mag_a    = cneg_x(bus.rs1_data_i, sa);
   assign mag_b    = cneg_x(bus.rs2_data_i, sb);
   assign div_zero = (bus.rs2_data_i == '0);
   assign div_ovf  = sa & sb & (bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                     & (bus.rs2_data_i == '1);

   // one restoring step: the shifted-in top bit acts as the guard bit, and
   // since the partial remainder stays below the divisor the difference
   // always fits back into XLEN bits when div_ge holds
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_rem_nxt;

   assign div_shift   = {rem_q, quo_q[XLEN-1]};
   assign div_ge      = (div_shift >= {1'b0, opb_q});
   assign div_rem_nxt = div_shift[XLEN-1:0] - opb_q;

   logic mul_last;
   assign mul_last = (cnt_q == '0) | (EARLY_OUT & (opb_q[XLEN-1:1] == '0));

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   assign prod_fix = cneg_w(acc_q, neg_1_q);
   assign quo_fix  = cneg_x(quo_q, neg_1_q);
   assign rem_fix  = cneg_x(rem_q, neg_2_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_mul_q <= 1'b0;
         neg_1_q  <= 1'b0;
         neg_2_q  <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         opb_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         data_1_q <= '0;
         data_2_q <= '0;
      end else if (bus.flush_i) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            // IDLE: latch magnitudes and result signs
            S_IDLE: begin
               if (bus.req_valid_i) begin
                  op_mul_q <= bus.mul_en_i;
                  cnt_q    <= CNT_W'(XLEN-1);
                  opb_q    <= mag_b;
                  state_q  <= S_CALC;
                  if (bus.mul_en_i) begin
                     acc_q   <= '0;
                     mcand_q <= {{XLEN{1'b0}}, mag_a};
                     neg_1_q <= sa ^ sb;
                     neg_2_q <= 1'b0;
                     if (EARLY_OUT && (mag_b == '0))
                        state_q <= S_FIX;
                  end else begin
                     quo_q   <= mag_a;
                     rem_q   <= '0;
                     // |a|/0 naturally yields all-ones, which must not be negated
                     neg_1_q <= (sa ^ sb) & ~div_zero;
                     neg_2_q <= sa;
                     if (EARLY_OUT && (div_zero || div_ovf)) begin
                        state_q <= S_FIX;
                        neg_1_q <= 1'b0;
                        neg_2_q <= 1'b0;
                        quo_q   <= div_zero ? '1 : bus.rs1_data_i;
                        rem_q   <= div_zero ? bus.rs1_data_i : '0;
                     end
                  end
               end
            end
            // CALC: one multiplier / quotient bit per cycle
            S_CALC: begin
               cnt_q <= cnt_q - 1'b1;
               if (op_mul_q) begin
                  if (opb_q[0])
                     acc_q <= acc_q + mcand_q;
                  mcand_q <= mcand_q << 1;
                  opb_q   <= opb_q >> 1;
                  if (mul_last)
                     state_q <= S_FIX;
               end else begin
                  rem_q <= div_ge ? div_rem_nxt : div_shift[XLEN-1:0];
                  quo_q <= {quo_q[XLEN-2:0], div_ge};
                  if (cnt_q == '0)
                     state_q <= S_FIX;
               end
            end
            // FIX: apply sign and publish results
            S_FIX: begin
               if (op_mul_q) begin
                  data_1_q <= prod_fix[XLEN-1:0];
                  data_2_q <= prod_fix[2*XLEN-1:XLEN];
               end else begin
                  data_1_q <= quo_fix;
                  data_2_q <= rem_fix;
               end
               state_q <= S_DONE;
            end
            // DONE: response cycle, never accepts
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o       = (state_q != S_IDLE);
   assign bus.resp_valid_o = (state_q == S_DONE);
   assign bus.data_1_o     = data_1_q;
   assign bus.data_2_o     = data_2_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed testbench for muldiv_unit: reset state, signed/unsigned
//   multiply and divide results, divide-by-zero and signed overflow,
//   response latency, back-to-back requests, flush and mid-op reset.
//   Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EO = 1'b1;
`else
   localparam bit EO = 1'b0;
`endif

   localparam int XLEN = 64;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   muldiv_unit_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // counts negedges until resp_valid_o is seen; 0 means it never came
   task automatic wait_resp(output int n);
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus.resp_valid_o) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic count_resp(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.resp_valid_o) pulses++;
      end
   endtask

   task automatic drive(input logic mul, input logic [63:0] a, input logic [63:0] b,
                        input logic sa, input logic sb);
      bus.mul_en_i   = mul;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
      bus.rs1_sign_i = sa;
      bus.rs2_sign_i = sb;
   endtask

   task automatic run_op(input string tag, input logic mul,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic sa, input logic sb,
                         input logic [63:0] e1, input logic [63:0] e2,
                         input int lat_eo);
      int n;
      @(negedge clk);
      drive(mul, a, b, sa, sb);
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      wait_resp(n);
      bus.req_valid_i = 1'b0;
      chk({tag, "_lat"}, 64'(n), 64'(EO ? lat_eo : 66));
      chk({tag, "_d1"}, bus.data_1_o, e1);
      chk({tag, "_d2"}, bus.data_2_o, e2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int pulses;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.req_valid_i = 1'b0;
      bus.flush_i     = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_resp", 64'(bus.resp_valid_o), 64'd0);
      chk("rst_d1", bus.data_1_o, 64'd0);
      chk("rst_d2", bus.data_2_o, 64'd0);
      rst = 1'b0;

      run_op("mul_3x5", 1'b1, 64'd3, 64'd5, 1'b1, 1'b1, 64'd15, 64'd0, 5);
      run_op("mul_m3x5", 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFF, 5);
      run_op("mulh_m1xm1", 1'b1, '1, '1, 1'b1, 1'b1, 64'd1, 64'd0, 3);
      run_op("mulhu_max", 1'b1, '1, '1, 1'b0, 1'b0,
             64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
      run_op("div_m7_2", 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66);
      run_op("div_7_m2", 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66);
      run_op("divu_100_7", 1'b0, 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 66);
      run_op("divu_7_0", 1'b0, 64'd7, 64'd0, 1'b0, 1'b0, '1, 64'd7, 2);
      run_op("div_m7_0", 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1, 1'b1,
             '1, 64'hFFFF_FFFF_FFFF_FFF9, 2);
      run_op("div_ovf", 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 1'b1,
             64'h8000_0000_0000_0000, 64'd0, 2);

      // request held high through DONE: one pulse, next accept at IDLE
      @(negedge clk);
      drive(1'b1, 64'd3, 64'd5, 1'b1, 1'b1);
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      wait_resp(n);
      chk("b2b_first_d1", bus.data_1_o, 64'd15);
      chk("b2b_done_busy", 64'(bus.busy_o), 64'd1);
      drive(1'b1, 64'd6, 64'd7, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_single_pulse", 64'(bus.resp_valid_o), 64'd0);
      chk("b2b_idle_busy", 64'(bus.busy_o), 64'd0);
      @(negedge clk);
      chk("b2b_accept_busy", 64'(bus.busy_o), 64'd1);
      drive(1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
      wait_resp(n);
      bus.req_valid_i = 1'b0;
      chk("b2b_second_lat", 64'(n + 1), 64'(EO ? 5 : 66));
      chk("b2b_second_d1", bus.data_1_o, 64'd42);
      chk("b2b_second_d2", bus.data_2_o, 64'd0);

      // flush at CALC cycle 10
      @(negedge clk);
      drive(1'b0, 64'd100, 64'd7, 1'b0, 1'b0);
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      repeat (10) @(negedge clk);
      bus.flush_i     = 1'b1;
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      bus.flush_i = 1'b0;
      chk("flush_busy", 64'(bus.busy_o), 64'd0);
      chk("flush_resp", 64'(bus.resp_valid_o), 64'd0);
      chk("flush_d1", bus.data_1_o, 64'd42);
      chk("flush_d2", bus.data_2_o, 64'd0);
      count_resp(80, pulses);
      chk("flush_no_resp", 64'(pulses), 64'd0);

      // flush beats accept in IDLE
      drive(1'b1, 64'd3, 64'd5, 1'b0, 1'b0);
      bus.req_valid_i = 1'b1;
      bus.flush_i     = 1'b1;
      @(negedge clk);
      chk("flush_req_busy", 64'(bus.busy_o), 64'd0);
      bus.req_valid_i = 1'b0;
      bus.flush_i     = 1'b0;
      count_resp(80, pulses);
      chk("flush_req_no_resp", 64'(pulses), 64'd0);

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      drive(1'b1, 64'd9, '1, 1'b0, 1'b0);
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      repeat (5) @(negedge clk);
      bus.req_valid_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 64'(bus.busy_o), 64'd0);
      chk("arst_resp", 64'(bus.resp_valid_o), 64'd0);
      chk("arst_d1", bus.data_1_o, 64'd0);
      chk("arst_d2", bus.data_2_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      count_resp(80, pulses);
      chk("arst_no_resp", 64'(pulses), 64'd0);

      run_op("post_rst_mul", 1'b1, 64'd6, 64'd7, 1'b0, 1'b0, 64'd42, 64'd0, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
